// File: rtl/uart_apb_sequencer_if.sv
// Byte-stream and APB3 signal bundle for uart_apb_sequencer.
// The master modport is the sequencer's view: it pushes/pops bytes and
// acts as the APB3 requester; the slave modport is the surrounding system.
interface uart_apb_sequencer_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  // TX byte push
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  // RX byte delivery
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_data;
  // APB3 requester outputs
  logic [AddressWidth-1:0] paddr;
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  // APB3 completer responses
  logic [DataWidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;
  // Status
  logic                    err;
  logic                    busy;

  modport master (
    input  in_valid, in_data, out_ready, prdata, pready, pslverr,
    output in_ready, out_valid, out_data, paddr, pselx, penable, pwrite,
           pwdata, err, busy
  );

  modport slave (
    output in_valid, in_data, out_ready, prdata, pready, pslverr,
    input  in_ready, out_valid, out_data, paddr, pselx, penable, pwrite,
           pwdata, err, busy
  );
endinterface

// File: rtl/uart_apb_sequencer.sv
// Bridges a byte stream to a memory-mapped UART over APB3: TX bytes are
// buffered in a small FIFO, the UART status register is polled, and the
// sequencer writes TX bytes / reads RX bytes, alternating when both are due.
module uart_apb_sequencer #(
  parameter int                    AddressWidth = 20,
  parameter int                    DataWidth    = 32,
  parameter int                    FifoDepth    = 4,
  parameter logic [AddressWidth-1:0] StatusAddr = 'h0,
  parameter logic [AddressWidth-1:0] TxDataAddr = 'h4,
  parameter logic [AddressWidth-1:0] RxDataAddr = 'h8,
  parameter int                    TxReadyBit   = 0,
  parameter int                    RxValidBit   = 1,
  parameter int                    PollInterval = 16
) (
  input logic                  clk,
  input logic                  rst,
  uart_apb_sequencer_if.master bus
);

  localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntWidth = (PollInterval > 1) ? $clog2(PollInterval) : 1;

  localparam logic [PtrWidth-1:0] PtrOne     = 1;
  localparam logic [PtrWidth:0]   CountOne   = 1;
  localparam logic [PtrWidth:0]   CountFull  = (PtrWidth+1)'(FifoDepth);
  localparam logic [CntWidth-1:0] CntOne     = 1;
  localparam logic [CntWidth-1:0] PollReload = CntWidth'(PollInterval - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_SETUP,
    S_POLL_ACCESS,
    S_WR_SETUP,
    S_WR_ACCESS,
    S_RD_SETUP,
    S_RD_ACCESS
  } state_t;

  typedef enum logic {
    SERVED_TX,
    SERVED_RX
  } served_t;

  state_t  state_q, state_d;
  served_t last_served_q;

  logic [7:0]          fifo_mem [FifoDepth];
  logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrWidth:0]   count_q;
  logic                full, empty, push, pop;
  logic [7:0]          fifo_head;

  logic [CntWidth-1:0] poll_cnt_q;

  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       err_q;

  logic in_access, rx_ok, tx_ok, wr_ok, rd_ok, slv_err;
  logic unused_prdata_bits;

  // Only the byte lane and the two status bits of prdata carry meaning.
  assign unused_prdata_bits = ^bus.prdata;

  assign full      = (count_q == CountFull);
  assign empty     = (count_q == '0);
  assign fifo_head = fifo_mem[rd_ptr_q];
  assign push      = bus.in_valid && !full;

  // Responses count only while an ACCESS phase is on the bus.
  assign in_access = (state_q == S_POLL_ACCESS) || (state_q == S_WR_ACCESS) ||
                     (state_q == S_RD_ACCESS);
  assign slv_err   = in_access && bus.pready && bus.pslverr;
  assign wr_ok     = (state_q == S_WR_ACCESS) && bus.pready && !bus.pslverr;
  assign rd_ok     = (state_q == S_RD_ACCESS) && bus.pready && !bus.pslverr;
  assign pop       = wr_ok;

  assign rx_ok = bus.prdata[RxValidBit] && !out_valid_q;
  assign tx_ok = bus.prdata[TxReadyBit] && !empty;

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_IDLE);

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and APB outputs, all derived from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty || (poll_cnt_q == '0)) state_d = S_POLL_SETUP;
      end
      S_POLL_SETUP: begin
        bus.pselx = 1'b1;
        bus.paddr = StatusAddr;
        state_d   = S_POLL_ACCESS;
      end
      S_POLL_ACCESS: begin
        bus.pselx   = 1'b1;
        bus.penable = 1'b1;
        bus.paddr   = StatusAddr;
        if (bus.pready) begin
          if (bus.pslverr)         state_d = S_IDLE;
          else if (rx_ok && tx_ok) state_d = (last_served_q == SERVED_TX) ? S_RD_SETUP
                                                                           : S_WR_SETUP;
          else if (rx_ok)          state_d = S_RD_SETUP;
          else if (tx_ok)          state_d = S_WR_SETUP;
          else                     state_d = S_IDLE;
        end
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        bus.pselx   = 1'b1;
        bus.penable = (state_q == S_WR_ACCESS);
        bus.pwrite  = 1'b1;
        bus.paddr   = TxDataAddr;
        bus.pwdata  = DataWidth'(fifo_head);
        if (state_q == S_WR_SETUP) state_d = S_WR_ACCESS;
        else if (bus.pready)       state_d = S_IDLE;
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        bus.pselx   = 1'b1;
        bus.penable = (state_q == S_RD_ACCESS);
        bus.paddr   = RxDataAddr;
        if (state_q == S_RD_SETUP) state_d = S_RD_ACCESS;
        else if (bus.pready)       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Poll timer: counts idle cycles down to zero, reloads whenever IDLE is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= PollReload;
    end else if (state_q == S_IDLE) begin
      if (state_d != S_IDLE)    poll_cnt_q <= PollReload;
      else if (poll_cnt_q != '0) poll_cnt_q <= poll_cnt_q - CntOne;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the array has no reset; entries are only read once the pointers
  // say they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.in_data;
  end

  // RX holding register, arbitration history and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      last_served_q <= SERVED_TX;
      err_q         <= 1'b0;
    end else begin
      err_q <= slv_err;
      if (rd_ok) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.prdata[7:0];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (wr_ok)      last_served_q <= SERVED_TX;
      else if (rd_ok) last_served_q <= SERVED_RX;
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer with a simple UART register model
// answering on the APB side.
module tb_uart_apb_sequencer;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Completer model state.
  logic [1:0] status_bits;
  logic [7:0] rx_byte;
  logic       stall;
  logic       slverr_wr;
  logic [7:0] wr_log[$];

  uart_apb_sequencer_if #(.AddressWidth(20), .DataWidth(32)) bus ();

  uart_apb_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.prdata  = (bus.paddr == 20'h0) ? {30'b0, status_bits} :
                       (bus.paddr == 20'h8) ? {24'b0, rx_byte} : 32'h0;
  assign bus.pready  = !stall;
  assign bus.pslverr = slverr_wr && (bus.paddr == 20'h4);

  // Record every successfully completed TX write.
  always @(posedge clk) begin
    if (bus.pselx && bus.penable && bus.pwrite && bus.pready && !bus.pslverr)
      wr_log.push_back(bus.pwdata[7:0]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr_setup(input string tag);
    int n = 0;
    while (!(bus.pselx && !bus.penable && bus.pwrite) && n < 200) begin
      tick();
      n++;
    end
    check(tag, bus.pselx && !bus.penable && bus.pwrite, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    status_bits   = 2'b01;
    rx_byte       = 8'h00;
    stall         = 1'b0;
    slverr_wr     = 1'b0;
    do_reset();

    // Reset state
    check("rst_pselx",     bus.pselx, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_err",       bus.err, 0);
    check("rst_apb",       {bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);

    // TX path: push 0x62, status TX-ready
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h62;
    tick();
    bus.in_valid = 1'b0;
    check("t1_idle_busy", bus.busy, 0);
    tick();
    check("t1_poll_setup", {bus.pselx, bus.penable, bus.pwrite, bus.paddr}, {3'b100, 20'h0});
    tick();
    check("t1_poll_access", {bus.pselx, bus.penable, bus.pwrite, bus.paddr}, {3'b110, 20'h0});
    tick();
    check("t1_wr_setup", {bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
          {3'b101, 20'h4, 32'h62});
    tick();
    check("t1_wr_access", {bus.pselx, bus.penable, bus.pwrite}, 3'b111);
    tick();
    check("t1_done", {bus.busy, bus.err, bus.in_ready, bus.pselx}, 4'b0010);
    check("t1_wr_log", (wr_log.size() == 1) ? wr_log[0] : 8'hxx, 8'h62);

    // RX path: empty FIFO, poll after 16 idle cycles, then RD
    status_bits = 2'b10;
    rx_byte     = 8'h41;
    n = 0;
    while (!bus.pselx && n < 100) begin
      tick();
      n++;
    end
    check("t2_idle_cycles", n, 16);
    tick();
    tick();
    check("t2_rd_setup", {bus.pselx, bus.penable, bus.pwrite, bus.paddr}, {3'b100, 20'h8});
    tick();
    tick();
    check("t2_out", {bus.out_valid, bus.out_data, bus.busy}, {1'b1, 8'h41, 1'b0});
    n = 0;
    while (!bus.pselx && n < 100) begin
      tick();
      n++;
    end
    check("t2_second_poll", n, 16);
    tick();
    tick();
    check("t2_rd_skipped", {bus.pselx, bus.busy, bus.out_valid, bus.out_data},
          {2'b00, 1'b1, 8'h41});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t2_drained", bus.out_valid, 0);

    // Alternation: both ready, RX first after reset, then TX
    do_reset();
    status_bits  = 2'b11;
    rx_byte      = 8'h55;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t3_rd_first", {bus.pselx, bus.penable, bus.pwrite, bus.paddr}, {3'b100, 20'h8});
    tick();
    tick();
    check("t3_rx_byte", {bus.out_valid, bus.out_data}, {1'b1, 8'h55});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t3_poll_again", {bus.out_valid, bus.pselx, bus.penable, bus.paddr}, {3'b010, 20'h0});
    tick();
    tick();
    check("t3_wr_second", {bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
          {3'b101, 20'h4, 32'hAA});
    tick();
    tick();
    check("t3_idle", bus.busy, 0);

    // FIFO full, refill after a pop, order preserved
    status_bits = 2'b00;
    wr_log.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h11 + 8'(i);
      tick();
    end
    check("t4_full", bus.in_ready, 0);
    bus.in_data = 8'h15;
    status_bits = 2'b01;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    check("t4_space_after_pop", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("t4_full_again", bus.in_ready, 0);
    n = 0;
    while (wr_log.size() < 5 && n < 300) begin
      tick();
      n++;
    end
    check("t4_drain_count", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_order_%0d", i), (i < wr_log.size()) ? wr_log[i] : 8'hxx,
            8'h11 + 8'(i));
    end
    check("t4_empty", bus.in_ready, 1);

    // Error on WR with a stalled ACCESS, then retry
    status_bits = 2'b00;
    wr_log.delete();
    tick();
    tick();
    status_bits  = 2'b01;
    slverr_wr    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    wait_wr_setup("t5_wr_setup_seen");
    stall = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_stable_%0d", i),
            {bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
            {3'b111, 20'h4, 32'h77});
      tick();
    end
    stall = 1'b0;
    tick();
    slverr_wr = 1'b0;
    check("t5_err_pulse", {bus.err, bus.busy}, 2'b10);
    check("t5_no_write_logged", wr_log.size(), 0);
    tick();
    check("t5_err_clear", bus.err, 0);
    wait_wr_setup("t5_retry_seen");
    check("t5_retry_data", bus.pwdata, 32'h77);
    tick();
    tick();
    check("t5_retry_done", (wr_log.size() == 1) ? wr_log[0] : 8'hxx, 8'h77);

    // Reset in the middle of a WR access
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    wait_wr_setup("t6_wr_setup_seen");
    stall = 1'b1;
    tick();
    check("t6_in_access", {bus.pselx, bus.penable}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    check("t6_after_rst", {bus.pselx, bus.busy, bus.in_ready, bus.out_valid}, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
